expr_sig_compactor: RTL

- Sits directly downstream of a combinational expression-under-test block and consumes its 90-bit packed result bus `y`.
- Compresses a programmable-length stream of results into a 32-bit MISR signature.
- At the end of the run, compares the signature against an expected value and reports pass/fail.
- Lets a regression check thousands of expression evaluations with one compare.

---
 rtl/expr_sig_compactor.sv | 122 ++++++++++++
 1 files changed

// File: rtl/expr_sig_compactor.sv
// MISR signature compactor for the 90-bit expression result bus: folds each
// accepted result into a 32-bit signature and compares it against a golden value.
module expr_sig_compactor #(
  parameter int                 Y_WIDTH   = 90,
  parameter int                 SIG_WIDTH = 32,
  parameter logic [SIG_WIDTH-1:0] POLY    = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED    = 32'hFFFFFFFF,
  parameter int                 CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_vectors,
  input  logic [SIG_WIDTH-1:0] expected_sig,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [Y_WIDTH-1:0]   in_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [CNT_WIDTH-1:0] vec_count
);

  localparam int NW = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PW = NW * SIG_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [SIG_WIDTH-1:0] exp_q, exp_d;
  logic                 pass_q, pass_d;

  logic [PW-1:0]        y_pad;
  logic [SIG_WIDTH-1:0] words [NW];
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] misr_next;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Zero-extend to a whole number of signature words and XOR them together.
  assign y_pad = PW'(in_y);

  generate
    for (genvar gi = 0; gi < NW; gi++) begin : g_word
      assign words[gi] = y_pad[gi*SIG_WIDTH +: SIG_WIDTH];
    end
  endgenerate

  always_comb begin
    fold = '0;
    for (int k = 0; k < NW; k++) begin
      fold = fold ^ words[k];
    end
  end

  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                   ^ fold;
  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vectors;
          exp_d   = expected_sig;
          // A zero-length run resolves immediately against the seed.
          pass_d  = (num_vectors == '0) && (SEED == expected_sig);
          state_d = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          sig_d = misr_next;
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            state_d = DONE;
            pass_d  = (misr_next == exp_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign vec_count = cnt_q;

endmodule
